// File: rtl/dpwm_pkg.sv
// dpwm_pkg: shared constants for the DPWM frequency path.
// Frequency index width, number of selectable frequencies and the
// index-to-period table (in CLK cycles at 100 MHz).
package dpwm_pkg;

  localparam int unsigned NUM_FREQ    = 8;
  localparam int unsigned FREQ_IDX_W  = 3;
  localparam int unsigned DEFAULT_IDX = 0;
  localparam int unsigned MIN_CNT_W   = 16;

  // 2, 4, 10, 20, 40, 50, 100, 200 kHz
  localparam int unsigned PERIODS [NUM_FREQ] = '{
    50000, 25000, 10000, 5000, 2500, 2000, 1000, 500
  };

endpackage

// File: rtl/dpwm_period_lut.sv
// dpwm_period_lut: combinational frequency index to switching period decode.
module dpwm_period_lut
  import dpwm_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic [FREQ_IDX_W-1:0] idx,
  output logic [CNT_W-1:0]      period
);

  // Table lookup, truncated to the counter width
  always_comb begin
    period = CNT_W'(PERIODS[idx]);
  end

endmodule

// File: rtl/dpwm_freq_divider.sv
// dpwm_freq_divider: programmable period counter producing the carrier ramp,
// a once-per-period tick and a 50 % square clock. The period is reloaded
// only at the wrap so index changes are glitch-free.
// Optional macro DPWM_DUTY_OUT_EN adds a shadowed duty input and pwm_out.
module dpwm_freq_divider
  import dpwm_pkg::*;
#(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned TICK_REG = 1
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  enable,
  input  logic [FREQ_IDX_W-1:0] numero_frec,
`ifdef DPWM_DUTY_OUT_EN
  input  logic [CNT_W-1:0]      duty,
  output logic                  pwm_out,
`endif
  output logic [CNT_W-1:0]      ramp,
  output logic [CNT_W-1:0]      period_act,
  output logic                  tick,
  output logic                  clk_div
);

  if (CNT_W < MIN_CNT_W) begin : g_width_check
    $error("dpwm_freq_divider: CNT_W must be at least 16 to hold the period table");
  end

  logic [CNT_W-1:0] ramp_q, ramp_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             clk_div_q, clk_div_d;
  logic [CNT_W-1:0] lut_period;
  logic             wrap;

  dpwm_period_lut #(
    .CNT_W (CNT_W)
  ) u_lut (
    .idx    (numero_frec),
    .period (lut_period)
  );

  // Wrap detection, next ramp, period shadow reload and square clock
  always_comb begin
    wrap      = enable && (ramp_q == (period_q - CNT_W'(1)));
    ramp_d    = ramp_q;
    period_d  = period_q;
    clk_div_d = clk_div_q;
    if (enable) begin
      if (wrap) begin
        ramp_d   = '0;
        period_d = lut_period;
      end else begin
        ramp_d = ramp_q + CNT_W'(1);
      end
      clk_div_d = (ramp_d < (period_d >> 1));
    end
  end

  // Counter, period and square-clock registers
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      ramp_q    <= '0;
      period_q  <= CNT_W'(PERIODS[DEFAULT_IDX]);
      clk_div_q <= 1'b0;
    end else begin
      ramp_q    <= ramp_d;
      period_q  <= period_d;
      clk_div_q <= clk_div_d;
    end
  end

  assign ramp       = ramp_q;
  assign period_act = period_q;
  assign clk_div    = clk_div_q;

  if (TICK_REG != 0) begin : g_tick_reg
    logic tick_q, tick_d;

    // Tick lands on the ramp==0 cycle following a wrap
    always_comb begin
      tick_d = wrap;
    end

    // Tick register
    always_ff @(posedge CLK) begin
      if (!RESET_N) begin
        tick_q <= 1'b0;
      end else begin
        tick_q <= tick_d;
      end
    end

    // Gated so a hold forces tick low even on the ramp==0 cycle
    assign tick = tick_q & enable;
  end else begin : g_tick_comb
    assign tick = wrap;
  end

`ifdef DPWM_DUTY_OUT_EN
  logic [CNT_W-1:0] duty_q, duty_d;
  logic             pwm_q, pwm_d;

  // Duty shadowed at the wrap; compare uses the value in force for next_ramp
  always_comb begin
    duty_d = duty_q;
    pwm_d  = pwm_q;
    if (wrap) begin
      duty_d = duty;
    end
    if (enable) begin
      pwm_d = (ramp_d < duty_d);
    end
  end

  // Duty shadow and PWM registers
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      duty_q <= '0;
      pwm_q  <= 1'b0;
    end else begin
      duty_q <= duty_d;
      pwm_q  <= pwm_d;
    end
  end

  assign pwm_out = pwm_q;
`endif

endmodule

// File: tb/tb_dpwm_freq_divider.sv
// tb_dpwm_freq_divider: directed self-checking bench for dpwm_freq_divider
// (default parameters, TICK_REG=1). Duty checks build only with
// DPWM_DUTY_OUT_EN defined.
module tb_dpwm_freq_divider;

  localparam int unsigned CNT_W = 16;

  logic             CLK;
  logic             RESET_N;
  logic             enable;
  logic [2:0]       numero_frec;
  logic [CNT_W-1:0] ramp;
  logic [CNT_W-1:0] period_act;
  logic             tick;
  logic             clk_div;
`ifdef DPWM_DUTY_OUT_EN
  logic [CNT_W-1:0] duty;
  logic             pwm_out;
`endif

  int errors = 0;
  int checks = 0;

  dpwm_freq_divider #(
    .CNT_W    (CNT_W),
    .TICK_REG (1)
  ) dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .enable      (enable),
    .numero_frec (numero_frec),
`ifdef DPWM_DUTY_OUT_EN
    .duty        (duty),
    .pwm_out     (pwm_out),
`endif
    .ramp        (ramp),
    .period_act  (period_act),
    .tick        (tick),
    .clk_div     (clk_div)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance one clock; sample point is 1 time unit after the rising edge
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Step until ramp equals target, bounded; caller checks ok and steps
  task automatic wait_ramp(input int target, input int budget,
                           output int steps, output bit ok);
    steps = 0;
    while ((int'(ramp) != target) && (steps < budget)) begin
      step();
      steps++;
    end
    ok = (int'(ramp) == target);
  endtask

  task automatic test_reset();
    int  n;
    bit  ok;
    RESET_N     = 1'b0;
    enable      = 1'b0;
    numero_frec = 3'd7;
`ifdef DPWM_DUTY_OUT_EN
    duty        = '0;
`endif
    repeat (3) step();
    checks++; if (ramp !== 16'd0) begin errors++; $display("FAIL reset_ramp got=%0d exp=0", ramp); end
    checks++; if (period_act !== 16'd50000) begin errors++; $display("FAIL reset_period got=%0d exp=50000", period_act); end
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick got=%b exp=0", tick); end
    checks++; if (clk_div !== 1'b0) begin errors++; $display("FAIL reset_clk_div got=%b exp=0", clk_div); end
`ifdef DPWM_DUTY_OUT_EN
    checks++; if (pwm_out !== 1'b0) begin errors++; $display("FAIL reset_pwm got=%b exp=0", pwm_out); end
`endif
    RESET_N = 1'b1;
    enable  = 1'b1;
    // First period after reset still uses the reset period
    wait_ramp(49999, 60000, n, ok);
    checks++; if (!ok || n != 49999) begin errors++; $display("FAIL first_period_len got=%0d exp=49999 ok=%0d", n, ok); end
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL first_zero_no_tick got=%b exp=0", tick); end
    step();
    checks++; if (ramp !== 16'd0) begin errors++; $display("FAIL first_wrap_ramp got=%0d exp=0", ramp); end
    checks++; if (period_act !== 16'd500) begin errors++; $display("FAIL first_wrap_period got=%0d exp=500", period_act); end
    checks++; if (tick !== 1'b1) begin errors++; $display("FAIL first_wrap_tick got=%b exp=1", tick); end
    checks++; if (clk_div !== 1'b1) begin errors++; $display("FAIL first_wrap_clk_div got=%b exp=1", clk_div); end
  endtask

  task automatic test_free_run();
    int ticks = 0;
    int highs = 0;
    int bad   = 0;
    for (int i = 0; i < 1000; i++) begin
      if (tick === 1'b1) begin
        ticks++;
        if (ramp !== 16'd0) bad++;
      end
      if (clk_div === 1'b1) highs++;
      if (clk_div !== (ramp < 16'd250)) bad++;
      if (ramp !== 16'(i % 500)) bad++;
      step();
    end
    checks++; if (ticks != 2) begin errors++; $display("FAIL free_run_ticks got=%0d exp=2", ticks); end
    checks++; if (highs != 500) begin errors++; $display("FAIL free_run_clk_div_high got=%0d exp=500", highs); end
    checks++; if (bad != 0) begin errors++; $display("FAIL free_run_pattern got=%0d exp=0 bad cycles", bad); end
  endtask

  task automatic test_mid_change();
    int n;
    bit ok;
    wait_ramp(100, 600, n, ok);
    numero_frec = 3'd6;
    wait_ramp(499, 600, n, ok);
    checks++; if (!ok || period_act !== 16'd500) begin errors++; $display("FAIL mid_change_before_wrap got=%0d exp=500", period_act); end
    step();
    checks++; if (ramp !== 16'd0 || period_act !== 16'd1000) begin
      errors++; $display("FAIL mid_change_after_wrap got ramp=%0d period=%0d exp ramp=0 period=1000", ramp, period_act);
    end
    numero_frec = 3'd7;
    wait_ramp(999, 1100, n, ok);
    checks++; if (!ok || n != 999) begin errors++; $display("FAIL mid_change_len got=%0d exp=999", n); end
    step();
    checks++; if (period_act !== 16'd500 || tick !== 1'b1) begin
      errors++; $display("FAIL mid_change_return got period=%0d tick=%b exp period=500 tick=1", period_act, tick);
    end
  endtask

  task automatic test_change_on_wrap();
    int n;
    bit ok;
    wait_ramp(498, 600, n, ok);
    step();
    numero_frec = 3'd5;
    checks++; if (ramp !== 16'd499 || period_act !== 16'd500) begin
      errors++; $display("FAIL wrap_change_pre got ramp=%0d period=%0d exp ramp=499 period=500", ramp, period_act);
    end
    step();
    checks++; if (ramp !== 16'd0 || period_act !== 16'd2000) begin
      errors++; $display("FAIL wrap_change_post got ramp=%0d period=%0d exp ramp=0 period=2000", ramp, period_act);
    end
    numero_frec = 3'd7;
    wait_ramp(1999, 2100, n, ok);
    checks++; if (!ok || n != 1999) begin errors++; $display("FAIL wrap_change_len got=%0d exp=1999", n); end
    step();
    checks++; if (period_act !== 16'd500) begin errors++; $display("FAIL wrap_change_return got=%0d exp=500", period_act); end
  endtask

  task automatic test_enable_hold();
    int n;
    bit ok;
    int bad = 0;
    wait_ramp(123, 600, n, ok);
    enable = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (ramp !== 16'd123 || tick !== 1'b0 || clk_div !== 1'b1 || period_act !== 16'd500) bad++;
    end
    checks++; if (!ok || bad != 0) begin errors++; $display("FAIL hold_frozen got=%0d exp=0 bad cycles", bad); end
    enable = 1'b1;
    step();
    checks++; if (ramp !== 16'd124) begin errors++; $display("FAIL hold_resume got=%0d exp=124", ramp); end
    wait_ramp(0, 600, n, ok);
    checks++; if (!ok || n != 376) begin errors++; $display("FAIL hold_remaining got=%0d exp=376", n); end
    checks++; if (tick !== 1'b1) begin errors++; $display("FAIL hold_wrap_tick got=%b exp=1", tick); end
    enable = 1'b0;
    #1;
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL hold_tick_gated got=%b exp=0", tick); end
    enable = 1'b1;
  endtask

`ifdef DPWM_DUTY_OUT_EN
  task automatic test_duty();
    int n;
    bit ok;
    int highs = 0;
    int bad   = 0;
    duty = 16'd125;
    wait_ramp(499, 600, n, ok);
    step();
    for (int i = 0; i < 500; i++) begin
      if (pwm_out === 1'b1) highs++;
      if (pwm_out !== (ramp < 16'd125)) bad++;
      step();
    end
    checks++; if (highs != 125 || bad != 0) begin
      errors++; $display("FAIL duty_125 got high=%0d bad=%0d exp high=125 bad=0", highs, bad);
    end
    wait_ramp(200, 600, n, ok);
    duty  = 16'd600;
    highs = 0;
    for (int i = 0; i < 300; i++) begin
      if (pwm_out === 1'b1) highs++;
      step();
    end
    checks++; if (highs != 0) begin errors++; $display("FAIL duty_shadowed got=%0d exp=0", highs); end
    highs = 0;
    for (int i = 0; i < 500; i++) begin
      if (pwm_out === 1'b1) highs++;
      step();
    end
    checks++; if (highs != 500) begin errors++; $display("FAIL duty_full got=%0d exp=500", highs); end
  endtask
`endif

  task automatic test_reset_mid();
    int n;
    bit ok;
    numero_frec = 3'd6;
    wait_ramp(499, 600, n, ok);
    step();
    checks++; if (period_act !== 16'd1000) begin errors++; $display("FAIL reset_mid_setup got=%0d exp=1000", period_act); end
    wait_ramp(300, 1100, n, ok);
    RESET_N = 1'b0;
    step();
    checks++; if (ramp !== 16'd0 || period_act !== 16'd50000) begin
      errors++; $display("FAIL reset_mid_state got ramp=%0d period=%0d exp ramp=0 period=50000", ramp, period_act);
    end
    checks++; if (clk_div !== 1'b0 || tick !== 1'b0) begin
      errors++; $display("FAIL reset_mid_outputs got clk_div=%b tick=%b exp 0 0", clk_div, tick);
    end
    RESET_N = 1'b1;
    step();
    checks++; if (ramp !== 16'd1 || period_act !== 16'd50000) begin
      errors++; $display("FAIL reset_mid_restart got ramp=%0d period=%0d exp ramp=1 period=50000", ramp, period_act);
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_mid_change();
    test_change_on_wrap();
    test_enable_hold();
`ifdef DPWM_DUTY_OUT_EN
    test_duty();
`endif
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
